// File: rtl/smg_pkg.sv
// Shared definitions for the seven-segment scan path: digit geometry,
// display mode codes, the frame snapshot record and the word selector.
package smg_pkg;

  localparam int NDIG   = 8;                  // digits per frame
  localparam int NIB_W  = 4;                  // bits per BCD nibble
  localparam int DIG_W  = $clog2(NDIG);       // digit select width
  localparam int WORD_W = NDIG * NIB_W;       // packed BCD word width

  // Mode codes; code 3 is an alias of TM.
  localparam logic [1:0] DM_FX = 2'd0;
  localparam logic [1:0] DM_TM = 2'd1;
  localparam logic [1:0] DM_ZK = 2'd2;

  // One coherent frame worth of display data.
  typedef struct packed {
    logic [1:0]        d_m;
    logic [WORD_W-1:0] fx;
    logic [WORD_W-1:0] tm;
    logic [WORD_W-1:0] zk;
  } snap_t;

  // Pick the word whose leading zeros are blanked for a given mode.
  function automatic logic [WORD_W-1:0] sel_word(input logic [1:0]        dm,
                                                 input logic [WORD_W-1:0] fx,
                                                 input logic [WORD_W-1:0] tm,
                                                 input logic [WORD_W-1:0] zk);
    logic [WORD_W-1:0] w;
    case (dm)
      DM_FX:   w = fx;
      DM_ZK:   w = zk;
      default: w = tm;                        // modes 1 and 3
    endcase
    return w;
  endfunction

endpackage

// File: rtl/smg_scan_ctrl_if.sv
// Signal bundle between the scan controller and its environment.
// master = the side that supplies data and controls the scan,
// slave  = the scan controller itself.
interface smg_scan_ctrl_if;
  import smg_pkg::*;

  logic              en;
  logic              load;
  logic [1:0]        d_m_in;
  logic [WORD_W-1:0] data_fx_in;
  logic [WORD_W-1:0] data_tm_in;
  logic [WORD_W-1:0] data_zk_in;

  logic [DIG_W-1:0]  bit_sel;
  logic [1:0]        d_m;
  logic [WORD_W-1:0] data_fx;
  logic [WORD_W-1:0] data_tm;
  logic [WORD_W-1:0] data_zk;
  logic              frame_start;
  logic              blank;

  modport master (
    output en, load, d_m_in, data_fx_in, data_tm_in, data_zk_in,
    input  bit_sel, d_m, data_fx, data_tm, data_zk, frame_start, blank
  );

  modport slave (
    input  en, load, d_m_in, data_fx_in, data_tm_in, data_zk_in,
    output bit_sel, d_m, data_fx, data_tm, data_zk, frame_start, blank
  );

endinterface

// File: rtl/smg_lz_mask.sv
// Leading-zero mask for one packed-BCD word. Bit i is set when digits
// 0..i (most significant first) are all zero; bit 7 is never set so an
// all-zero value still shows one "0". Non-BCD nibbles count as non-zero.
module smg_lz_mask
  import smg_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  output logic [NDIG-1:0]   mask_o
);

  // Running AND of "nibble is zero" from the most significant digit down.
  always_comb begin
    logic run;
    // NOTE: every combinational output gets a default before any branch or
    // loop so no path leaves it unassigned, which would infer a latch.
    mask_o = '0;
    run    = 1'b1;
    for (int i = 0; i < NDIG - 1; i++) begin
      run       = run & (word_i[WORD_W-1-i*NIB_W -: NIB_W] == '0);
      mask_o[i] = run;
    end
  end

endmodule

// File: rtl/smg_scan_ctrl.sv
// Digit scan controller for an 8-digit seven-segment display. Holds each
// digit for DWELL_CYCLES enabled clocks, snapshots the display sources at
// every frame boundary (or on load) so a whole scan shows one value, and
// flags leading-zero digits for blanking.
module smg_scan_ctrl
  import smg_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000,         // must be >= 2
  parameter bit LZB_EN       = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  smg_scan_ctrl_if.slave bus
);

  localparam int            PW     = $clog2(DWELL_CYCLES);
  localparam logic [PW-1:0] PS_MAX = PW'(DWELL_CYCLES - 1);
  localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(NDIG - 1);

  logic [PW-1:0]    presc_q, presc_d;
  logic [DIG_W-1:0] bit_sel_q, bit_sel_d;
  logic             frame_start_q, frame_start_d;
  snap_t            snap_q, snap_d;
  logic [NDIG-1:0]  lz_mask_q, lz_mask_d;

  logic             tick;
  logic             boundary;
  logic             take_snap;
  logic [WORD_W-1:0] new_word;
  logic [NDIG-1:0]  new_mask;

  assign tick      = bus.en && (presc_q == PS_MAX);
  assign boundary  = tick && (bit_sel_q == LAST_DIG);
  assign take_snap = boundary || bus.load;

  // The mask is computed from the incoming selection so it lands in the
  // same edge as the snapshot it describes.
  assign new_word = sel_word(bus.d_m_in, bus.data_fx_in, bus.data_tm_in,
                             bus.data_zk_in);

  smg_lz_mask u_lz_mask (
    .word_i (new_word),
    .mask_o (new_mask)
  );

  // Next-state: prescaler, digit counter, frame pulse and snapshot.
  always_comb begin
    presc_d       = presc_q;
    bit_sel_d     = bit_sel_q;
    frame_start_d = 1'b0;
    snap_d        = snap_q;
    lz_mask_d     = lz_mask_q;

    if (bus.load) begin
      // load restarts the frame regardless of en; a coincident boundary
      // lands in the same state, so there is only one pulse.
      presc_d   = '0;
      bit_sel_d = '0;
    end else if (tick) begin
      presc_d   = '0;
      bit_sel_d = bit_sel_q + DIG_W'(1);      // wraps 7 -> 0
    end else if (bus.en) begin
      presc_d   = presc_q + PW'(1);
    end

    if (take_snap) begin
      frame_start_d = 1'b1;
      snap_d.d_m    = bus.d_m_in;
      snap_d.fx     = bus.data_fx_in;
      snap_d.tm     = bus.data_tm_in;
      snap_d.zk     = bus.data_zk_in;
      lz_mask_d     = new_mask;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples its next value from the same pre-edge snapshot.
    if (!rst_n) begin
      presc_q       <= '0;
      bit_sel_q     <= '0;
      frame_start_q <= 1'b0;
      snap_q        <= '0;
      lz_mask_q     <= 8'h7F;
    end else begin
      presc_q       <= presc_d;
      bit_sel_q     <= bit_sel_d;
      frame_start_q <= frame_start_d;
      snap_q        <= snap_d;
      lz_mask_q     <= lz_mask_d;
    end
  end

  assign bus.bit_sel     = bit_sel_q;
  assign bus.d_m         = snap_q.d_m;
  assign bus.data_fx     = snap_q.fx;
  assign bus.data_tm     = snap_q.tm;
  assign bus.data_zk     = snap_q.zk;
  assign bus.frame_start = frame_start_q;
  assign bus.blank       = LZB_EN && lz_mask_q[bit_sel_q];

endmodule
